// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter and its lane steering.
// Also hosts the RV32I load/store opcode enum used by the LSU side of the core.
package dmem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    RV_LB, RV_LH, RV_LW, RV_LBU, RV_LHU, RV_SB, RV_SH, RV_SW
  } rv32i_instr_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Encoding 2'b11 is accepted as a word access.
  function automatic mem_size_e decode_size(input logic [1:0] size);
    case (size)
      2'b00:   decode_size = MEM_B;
      2'b01:   decode_size = MEM_H;
      default: decode_size = MEM_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
    case (size)
      MEM_B:   byte_en = 4'b0001 << off;
      MEM_H:   byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational store-lane steering: byte enables, replicated write data and
// misalignment detection for one LSU access.
module dmem_lane_steer
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] lane_wdata,
  output logic        misaligned
);

  mem_size_e sz;

  // Replicating the data lets the byte enables alone select the target lanes.
  always_comb begin
    sz         = decode_size(size);
    we         = byte_en(sz, offset);
    lane_wdata = wdata;
    misaligned = 1'b0;
    case (sz)
      MEM_B: begin
        lane_wdata = {4{wdata[7:0]}};
      end
      MEM_H: begin
        lane_wdata = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        lane_wdata = wdata;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates fetch and LSU onto one single-ported, 1-cycle-latency data memory,
// with a fairness streak limit and a response tag for routing read data back.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              lsu_read_en,
  input  logic              lsu_write_en,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [1:0]        lsu_size,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [31:0]       lsu_rdata,
  output logic              misalign_err,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(FAIR_LIMIT);

  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                rsp_valid, rsp_read;
  owner_e              rsp_owner;
  logic [1:0]          rsp_off;

  logic        lsu_req, fetch_force, lsu_issue;
  logic [3:0]  steer_we;
  logic [31:0] steer_wdata;
  logic        misaligned;

  assign lsu_req = lsu_read_en | lsu_write_en;

  dmem_lane_steer u_steer (
    .size       (lsu_size),
    .offset     (lsu_addr[1:0]),
    .wdata      (lsu_wdata),
    .we         (steer_we),
    .lane_wdata (steer_wdata),
    .misaligned (misaligned)
  );

  // LSU (older instruction) wins unless fetch has starved for FAIR_LIMIT grants.
  always_comb begin
    fetch_force = 1'b0;
    if_gnt      = 1'b0;
    lsu_gnt     = 1'b0;
    if (!rst) begin
      fetch_force = if_req && (streak == LIMIT);
      if (lsu_req && !fetch_force) lsu_gnt = 1'b1;
      else if (if_req)             if_gnt  = 1'b1;
    end
  end

  assign stall        = !rst && ((if_req && !if_gnt) || (lsu_req && !lsu_gnt));
  assign misalign_err = lsu_gnt && misaligned;
  assign lsu_issue    = lsu_gnt && !misaligned;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
    end else if (lsu_issue) begin
      mem_en   = 1'b1;
      mem_addr = {lsu_addr[ADDR_W-1:2], 2'b00};
      if (lsu_write_en) begin
        mem_we    = steer_we;
        mem_wdata = steer_wdata;
      end
    end
  end

  always_comb begin
    streak_nxt = streak;
    if (!if_req || if_gnt) streak_nxt = '0;
    else if (lsu_gnt)      streak_nxt = streak + 1'b1;
  end

  // The tag remembers who owns the data arriving next cycle and how to align it.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak    <= '0;
      rsp_valid <= 1'b0;
      rsp_read  <= 1'b0;
      rsp_owner <= OWN_IF;
      rsp_off   <= 2'b00;
    end else begin
      streak    <= streak_nxt;
      rsp_valid <= if_gnt || lsu_issue;
      if (if_gnt || lsu_gnt) begin
        rsp_read  <= if_gnt || lsu_read_en;
        rsp_owner <= if_gnt ? OWN_IF : OWN_LSU;
        rsp_off   <= if_gnt ? if_addr[1:0] : lsu_addr[1:0];
      end
    end
  end

  assign if_rvalid  = !rst && rsp_valid && rsp_read && (rsp_owner == OWN_IF);
  assign lsu_rvalid = !rst && rsp_valid && rsp_read && (rsp_owner == OWN_LSU);
  assign if_rdata   = if_rvalid  ? mem_rdata : 32'h0;
  assign lsu_rdata  = lsu_rvalid ? (mem_rdata >> {rsp_off, 3'b000}) : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int FAIR = 4;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          lsu_read_en, lsu_write_en;
  logic [AW-1:0] lsu_addr;
  logic [1:0]    lsu_size;
  logic [31:0]   lsu_wdata;
  logic          lsu_gnt, lsu_rvalid;
  logic [31:0]   lsu_rdata;
  logic          misalign_err, stall, mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.FAIR_LIMIT(FAIR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_read_en(lsu_read_en), .lsu_write_en(lsu_write_en), .lsu_addr(lsu_addr),
    .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .misalign_err(misalign_err),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    lsu_read_en = 0; lsu_write_en = 0; lsu_addr = '0; lsu_size = 2'b10; lsu_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic lsu_op(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    lsu_read_en = !wr; lsu_write_en = wr; lsu_size = size; lsu_addr = addr; lsu_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; if_addr = 32'h40; lsu_op(1'b0, 2'b10, 32'h80, 32'h0);
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt, stall, mem_en, if_rvalid, lsu_rvalid, misalign_err, mem_we} !== 11'h0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl got=%0h exp=0", {if_gnt, lsu_gnt, stall, mem_en, if_rvalid, lsu_rvalid, misalign_err, mem_we});
    end
    vectors++;
    if ({mem_addr, mem_wdata, if_rdata, lsu_rdata} !== 128'h0) begin
      miscompares++; $display("[TB] FAIL reset_data addr=%0h wdata=%0h exp=0", mem_addr, mem_wdata);
    end
    tick();
    clear_inputs();
    tick();
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({if_rvalid, lsu_rvalid, stall, mem_en} !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset_release got=%0h exp=0", {if_rvalid, lsu_rvalid, stall, mem_en});
    end
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt, stall, mem_en, mem_we} !== 8'b1001_0000) begin
      miscompares++; $display("[TB] FAIL fetch_grant got=%0b exp=10010000", {if_gnt, lsu_gnt, stall, mem_en, mem_we});
    end
    vectors++;
    if (mem_addr !== 32'h100) begin
      miscompares++; $display("[TB] FAIL fetch_addr got=%0h exp=100", mem_addr);
    end
    tick();
    if_req = 0; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || lsu_rvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fetch_rdata rvalid=%0b data=%0h exp=1/deadbeef", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_store();
    lsu_op(1'b1, 2'b00, 32'h203, 32'h0000_00AB);
    @(negedge clk);
    vectors++;
    if (lsu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h200) begin
      miscompares++; $display("[TB] FAIL sb_issue gnt=%0b en=%0b addr=%0h exp=1/1/200", lsu_gnt, mem_en, mem_addr);
    end
    vectors++;
    if (mem_we !== 4'b1000 || mem_wdata !== 32'hABABABAB) begin
      miscompares++; $display("[TB] FAIL sb_lanes we=%0b wdata=%0h exp=1000/ababab", mem_we, mem_wdata);
    end
    tick();
    lsu_op(1'b1, 2'b01, 32'h202, 32'h0000_1234);
    @(negedge clk);
    vectors++;
    if (lsu_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL sb_no_rvalid got=%0b%0b exp=00", lsu_rvalid, if_rvalid);
    end
    vectors++;
    if (mem_we !== 4'b1100 || mem_wdata !== 32'h12341234 || mem_addr !== 32'h200) begin
      miscompares++; $display("[TB] FAIL sh_lanes we=%0b wdata=%0h exp=1100/12341234", mem_we, mem_wdata);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_load();
    lsu_op(1'b0, 2'b00, 32'h301, 32'h0);
    @(negedge clk);
    vectors++;
    if (lsu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0 || mem_addr !== 32'h300) begin
      miscompares++; $display("[TB] FAIL lb_issue gnt=%0b we=%0b addr=%0h exp=1/0/300", lsu_gnt, mem_we, mem_addr);
    end
    tick();
    clear_inputs(); mem_rdata = 32'h11223344;
    @(negedge clk);
    vectors++;
    if (lsu_rvalid !== 1'b1 || lsu_rdata[23:0] !== 24'h112233) begin
      miscompares++; $display("[TB] FAIL lb_rdata rvalid=%0b data=%0h exp=1/112233", lsu_rvalid, lsu_rdata[23:0]);
    end
    tick();
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 32'h500; lsu_op(1'b0, 2'b10, 32'h600, 32'h0);
    for (int c = 0; c < 10; c++) begin
      logic exp_if;
      exp_if = (c % (FAIR + 1)) == FAIR;
      @(negedge clk);
      vectors++;
      if (if_gnt !== exp_if || lsu_gnt !== !exp_if || stall !== 1'b1) begin
        miscompares++; $display("[TB] FAIL contention_c%0d if=%0b lsu=%0b stall=%0b exp_if=%0b", c, if_gnt, lsu_gnt, stall, exp_if);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_misaligned();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) lsu_op(1'b0, 2'b10, 32'h402, 32'h0);
      else        lsu_op(1'b0, 2'b01, 32'h401, 32'h0);
      @(negedge clk);
      vectors++;
      if (lsu_gnt !== 1'b1 || misalign_err !== 1'b1 || mem_en !== 1'b0 || stall !== 1'b0) begin
        miscompares++; $display("[TB] FAIL misalign_%0d gnt=%0b err=%0b en=%0b exp=1/1/0", k, lsu_gnt, misalign_err, mem_en);
      end
      tick();
      clear_inputs(); mem_rdata = 32'hCAFE0000;
      @(negedge clk);
      vectors++;
      if (lsu_rvalid !== 1'b0 || misalign_err !== 1'b0) begin
        miscompares++; $display("[TB] FAIL misalign_rsp_%0d rvalid=%0b err=%0b exp=0/0", k, lsu_rvalid, misalign_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_load();
    if_req = 1; if_addr = 32'h700; lsu_op(1'b0, 2'b00, 32'h301, 32'h0);
    tick();
    tick();
    rst = 1; mem_rdata = 32'h55667788;
    @(negedge clk);
    vectors++;
    if ({lsu_rvalid, if_rvalid, lsu_gnt, if_gnt, stall, mem_en, lsu_rdata} !== 38'h0) begin
      miscompares++; $display("[TB] FAIL reset_mid_load rvalid=%0b gnt=%0b%0b exp=0", lsu_rvalid, lsu_gnt, if_gnt);
    end
    tick();
    rst = 0;
    for (int c = 0; c < FAIR + 1; c++) begin
      @(negedge clk);
      vectors++;
      if (lsu_rvalid !== 1'b0 && c == 0) begin
        miscompares++; $display("[TB] FAIL post_reset_rvalid got=%0b exp=0", lsu_rvalid);
      end
      vectors++;
      if (if_gnt !== (c == FAIR)) begin
        miscompares++; $display("[TB] FAIL post_reset_streak_c%0d if_gnt=%0b exp=%0b", c, if_gnt, c == FAIR);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int streak = 0;
    logic pv_valid = 0, pv_read = 0, pv_lsu = 0;
    logic [1:0] pv_off = 0;
    logic if_pend = 0, lsu_pend = 0;
    for (int n = 0; n < 600; n++) begin
      int nb, base, off;
      logic mis, lreq, ig, lg, force_if;
      logic [3:0] we_exp;
      logic [31:0] wd_exp, addr_exp, mask;
      if (!if_pend) begin
        if_req = ($urandom_range(0, 99) < 55);
        if_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (!lsu_pend) begin
        if ($urandom_range(0, 99) < 60) lsu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom);
        else begin lsu_read_en = 0; lsu_write_en = 0; end
      end
      mem_rdata = $urandom;
      lreq = lsu_read_en || lsu_write_en;
      nb = (lsu_size == 2'b00) ? 1 : (lsu_size == 2'b01) ? 2 : 4;
      off = int'(lsu_addr[1:0]);
      base = off - (off % nb);
      mis = (off % nb) != 0;
      force_if = if_req && (streak == FAIR);
      lg = lreq && !force_if;
      ig = if_req && !lg;
      we_exp = '0; wd_exp = '0; addr_exp = '0;
      if (ig) addr_exp = if_addr & ~32'h3;
      else if (lg && !mis) begin
        addr_exp = lsu_addr & ~32'h3;
        if (lsu_write_en)
          for (int i = 0; i < 4; i++) begin
            we_exp[i] = (i >= base) && (i < base + nb);
            wd_exp[8*i +: 8] = lsu_wdata[8*(i % nb) +: 8];
          end
      end
      @(negedge clk);
      vectors++;
      if (if_gnt !== ig || lsu_gnt !== lg || stall !== ((if_req && !ig) || (lreq && !lg))) begin
        miscompares++; $display("[TB] FAIL rnd_arb n=%0d if=%0b lsu=%0b stall=%0b exp=%0b%0b streak=%0d", n, if_gnt, lsu_gnt, stall, ig, lg, streak);
      end
      vectors++;
      if (mem_en !== (ig || (lg && !mis)) || misalign_err !== (lg && mis)) begin
        miscompares++; $display("[TB] FAIL rnd_en n=%0d en=%0b err=%0b exp=%0b/%0b", n, mem_en, misalign_err, ig || (lg && !mis), lg && mis);
      end
      vectors++;
      if (mem_we !== we_exp || mem_wdata !== wd_exp || mem_addr !== addr_exp) begin
        miscompares++; $display("[TB] FAIL rnd_bus n=%0d we=%0b wd=%0h a=%0h exp=%0b/%0h/%0h", n, mem_we, mem_wdata, mem_addr, we_exp, wd_exp, addr_exp);
      end
      vectors++;
      if (if_rvalid !== (pv_valid && pv_read && !pv_lsu) || lsu_rvalid !== (pv_valid && pv_read && pv_lsu)) begin
        miscompares++; $display("[TB] FAIL rnd_rvalid n=%0d if=%0b lsu=%0b", n, if_rvalid, lsu_rvalid);
      end
      mask = 32'hFFFF_FFFF >> (8 * pv_off);
      if (pv_valid && pv_read) begin
        vectors++;
        if (pv_lsu ? ((lsu_rdata & mask) !== (mem_rdata >> (8 * pv_off))) : (if_rdata !== mem_rdata)) begin
          miscompares++; $display("[TB] FAIL rnd_rdata n=%0d if=%0h lsu=%0h mem=%0h off=%0d", n, if_rdata, lsu_rdata, mem_rdata, pv_off);
        end
      end
      pv_valid = ig || (lg && !mis);
      if (ig || lg) begin
        pv_read = ig || lsu_read_en;
        pv_lsu = lg;
        pv_off = ig ? if_addr[1:0] : lsu_addr[1:0];
      end
      if (!if_req || ig) streak = 0;
      else if (lg) streak++;
      if_pend = if_req && !ig;
      lsu_pend = lreq && !lg;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_fetch_only();
    test_store();
    test_load();
    test_contention();
    test_misaligned();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
